// File: rtl/ram_byte_ctrl.sv
// Byte-serial RAM controller: arbitrates instruction fetch and load/store round-robin,
// assembles little-endian words over an 8-bit synchronous RAM and extends loads.
module ram_byte_ctrl #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_BYTES = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    if_valid_in,
   input  logic [ADDR_WIDTH-1:0]   if_addr_in,
   output logic                    if_done_out,
   output logic [8*DATA_BYTES-1:0] if_data_out,
   input  logic                    ls_valid_in,
   input  logic                    ls_wr_in,
   input  logic [1:0]              ls_size_in,
   input  logic                    ls_sext_in,
   input  logic [ADDR_WIDTH-1:0]   ls_addr_in,
   input  logic [8*DATA_BYTES-1:0] ls_wdata_in,
   output logic                    ls_done_out,
   output logic [8*DATA_BYTES-1:0] ls_rdata_out,
   output logic                    mem_en_out,
   output logic                    mem_r_nw_out,
   output logic [ADDR_WIDTH-1:0]   mem_a_out,
   output logic [7:0]              mem_d_out,
   input  logic [7:0]              mem_d_in
);

   localparam int DW = 8 * DATA_BYTES;
   localparam int CW = $clog2(DATA_BYTES + 2);

   typedef enum logic [1:0] {ST_IDLE, ST_IF, ST_LOAD, ST_STORE} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         n_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DW-1:0]         wdata_q;
   logic                  sext_q;
   logic                  prio_ls;
   logic [DW-1:0]         rbuf;
   logic [DW-1:0]         rword;
   logic [7:0]            wbyte;
   logic                  grant_if;
   logic                  accept;

   function automatic logic [CW-1:0] byte_count(input logic [1:0] size);
      int n;
      n = 1 << size;
      if (n > DATA_BYTES) n = DATA_BYTES;
      return CW'(n);
   endfunction

   function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] w,
                                                 input logic [CW-1:0] n,
                                                 input logic sx);
      logic [DW-1:0] r;
      logic          fill;
      r    = w;
      fill = 1'b0;
      for (int j = 0; j < DATA_BYTES; j++)
         if (CW'(j) == n - CW'(1)) fill = sx & w[8*j+7];
      for (int j = 0; j < DATA_BYTES; j++)
         if (CW'(j) >= n) r[8*j +: 8] = {8{fill}};
      return r;
   endfunction

   always_comb begin
      grant_if = if_valid_in && (!ls_valid_in || !prio_ls);
      accept   = (state == ST_IDLE) && !if_done_out && !ls_done_out &&
                 (if_valid_in || ls_valid_in);
      // Read data for byte (cnt-2) arrives this cycle; merge it into the word.
      rword = rbuf;
      for (int j = 0; j < DATA_BYTES; j++)
         if (CW'(j) == cnt - CW'(2)) rword[8*j +: 8] = mem_d_in;
      wbyte = 8'h00;
      for (int j = 0; j < DATA_BYTES; j++)
         if (CW'(j) == cnt) wbyte = wdata_q[8*j +: 8];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         n_q          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         sext_q       <= 1'b0;
         prio_ls      <= 1'b0;
         rbuf         <= '0;
         if_done_out  <= 1'b0;
         if_data_out  <= '0;
         ls_done_out  <= 1'b0;
         ls_rdata_out <= '0;
         mem_en_out   <= 1'b0;
         mem_r_nw_out <= 1'b1;
         mem_a_out    <= '0;
         mem_d_out    <= '0;
      end else begin
         if_done_out <= 1'b0;
         ls_done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               mem_en_out   <= 1'b0;
               mem_r_nw_out <= 1'b1;
               if (accept) begin
                  cnt        <= CW'(1);
                  mem_en_out <= 1'b1;
                  if (grant_if) begin
                     state     <= ST_IF;
                     n_q       <= CW'(DATA_BYTES);
                     addr_q    <= if_addr_in;
                     mem_a_out <= if_addr_in;
                     sext_q    <= 1'b0;
                     prio_ls   <= 1'b1;
                  end else begin
                     n_q       <= byte_count(ls_size_in);
                     addr_q    <= ls_addr_in;
                     mem_a_out <= ls_addr_in;
                     sext_q    <= ls_sext_in;
                     wdata_q   <= ls_wdata_in;
                     prio_ls   <= 1'b0;
                     if (ls_wr_in) begin
                        state        <= ST_STORE;
                        mem_r_nw_out <= 1'b0;
                        mem_d_out    <= ls_wdata_in[7:0];
                     end else begin
                        state <= ST_LOAD;
                     end
                  end
               end
            end
            ST_IF, ST_LOAD: begin
               cnt <= cnt + CW'(1);
               if (cnt < n_q) mem_a_out <= addr_q + ADDR_WIDTH'(cnt);
               if (cnt == n_q) mem_en_out <= 1'b0;
               if (cnt >= CW'(2)) rbuf <= rword;
               // Last byte lands one cycle after the address phase ends.
               if (cnt == n_q + CW'(1)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
                  if (state == ST_IF) begin
                     if_done_out <= 1'b1;
                     if_data_out <= rword;
                  end else begin
                     ls_done_out  <= 1'b1;
                     ls_rdata_out <= extend_load(rword, n_q, sext_q);
                  end
               end
            end
            ST_STORE: begin
               if (cnt < n_q) begin
                  cnt       <= cnt + CW'(1);
                  mem_a_out <= addr_q + ADDR_WIDTH'(cnt);
                  mem_d_out <= wbyte;
               end else begin
                  cnt          <= '0;
                  state        <= ST_IDLE;
                  mem_en_out   <= 1'b0;
                  mem_r_nw_out <= 1'b1;
                  ls_done_out  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Directed bench for ram_byte_ctrl with a behavioural 8-bit synchronous RAM.
module tb_ram_byte_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        if_valid_in;
   logic [16:0] if_addr_in;
   logic        if_done_out;
   logic [31:0] if_data_out;
   logic        ls_valid_in;
   logic        ls_wr_in;
   logic [1:0]  ls_size_in;
   logic        ls_sext_in;
   logic [16:0] ls_addr_in;
   logic [31:0] ls_wdata_in;
   logic        ls_done_out;
   logic [31:0] ls_rdata_out;
   logic        mem_en_out;
   logic        mem_r_nw_out;
   logic [16:0] mem_a_out;
   logic [7:0]  mem_d_out;
   logic [7:0]  mem_d_in = 8'h00;

   logic [7:0]  ram [0:(1<<17)-1];
   logic [16:0] log_a [0:15];
   int          nlog, nwr, cyc;
   int          checks = 0;
   int          failures = 0;

   ram_byte_ctrl #(.ADDR_WIDTH(17), .DATA_BYTES(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .if_valid_in(if_valid_in), .if_addr_in(if_addr_in),
      .if_done_out(if_done_out), .if_data_out(if_data_out),
      .ls_valid_in(ls_valid_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
      .ls_sext_in(ls_sext_in), .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
      .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
      .mem_en_out(mem_en_out), .mem_r_nw_out(mem_r_nw_out), .mem_a_out(mem_a_out),
      .mem_d_out(mem_d_out), .mem_d_in(mem_d_in)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (mem_en_out) begin
         if (mem_r_nw_out) mem_d_in <= ram[mem_a_out];
         else              ram[mem_a_out] <= mem_d_out;
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic poke(input logic [16:0] a, input logic [7:0] v);
      ram[a] <= v;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req_ls(input logic wr, input logic [1:0] size, input logic sx,
                         input logic [16:0] a, input logic [31:0] wd);
      ls_wr_in    = wr;
      ls_size_in  = size;
      ls_sext_in  = sx;
      ls_addr_in  = a;
      ls_wdata_in = wd;
      ls_valid_in = 1'b1;
   endtask

   // Ticks until a done pulse, logging RAM accesses; cyc counts ticks including the done one.
   task automatic step_wait();
      logic got;
      got  = 1'b0;
      nlog = 0;
      nwr  = 0;
      cyc  = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
         tick();
         if (mem_en_out) begin
            if (nlog < 16) log_a[nlog] = mem_a_out;
            nlog++;
            if (!mem_r_nw_out) nwr++;
         end
         if (if_done_out || ls_done_out) begin
            got = 1'b1;
            cyc = c;
         end
      end
      checks++;
      assert (got) else begin
         failures++;
         $error("FAIL done_timeout: observed=no_done expected=done_within_40");
      end
   endtask

   // Requester drops valid in the done cycle; the next edge must clear the pulse.
   task automatic end_done(input logic drop_if, input logic drop_ls);
      if (drop_if) if_valid_in = 1'b0;
      if (drop_ls) ls_valid_in = 1'b0;
      tick();
      chk("done_one_cycle", {if_done_out, ls_done_out}, 2'b00);
   endtask

   initial begin
      rst_n_in    = 1'b0;
      if_valid_in = 1'b0;
      if_addr_in  = '0;
      ls_valid_in = 1'b0;
      ls_wr_in    = 1'b0;
      ls_size_in  = 2'd0;
      ls_sext_in  = 1'b0;
      ls_addr_in  = '0;
      ls_wdata_in = '0;
      poke(17'h100, 8'h80); poke(17'h101, 8'h11); poke(17'h102, 8'h22); poke(17'h103, 8'h83);
      poke(17'h10, 8'h55);  poke(17'h11, 8'h66);
      poke(17'h1FFFE, 8'hA1); poke(17'h1FFFF, 8'hB2); poke(17'h0, 8'hC3); poke(17'h1, 8'hD4);
      for (int i = 0; i < 4; i++) poke(17'h20 + 17'(i), 8'h00);
      tick();
      tick();
      chk("rst_mem_en", mem_en_out, 1'b0);
      chk("rst_mem_r_nw", mem_r_nw_out, 1'b1);
      chk("rst_mem_a", mem_a_out, 17'h0);
      chk("rst_mem_d", mem_d_out, 8'h0);
      chk("rst_dones", {if_done_out, ls_done_out}, 2'b00);
      chk("rst_data", {if_data_out, ls_rdata_out}, 64'h0);
      rst_n_in = 1'b1;
      tick();

      // Word load, sign-extend (no extension needed at full width)
      req_ls(1'b0, 2'd2, 1'b1, 17'h100, 32'h0);
      step_wait();
      chk("ld_word_done", {if_done_out, ls_done_out}, 2'b01);
      chk("ld_word_data", ls_rdata_out, 32'h83221180);
      chk("ld_word_latency", cyc - 1, 5);
      chk("ld_word_nacc", nlog, 4);
      chk("ld_word_addrs", {log_a[0], log_a[1], log_a[2], log_a[3]},
          {17'h100, 17'h101, 17'h102, 17'h103});
      end_done(1'b0, 1'b1);
      chk("idle_port", {mem_en_out, mem_r_nw_out}, 2'b01);

      req_ls(1'b0, 2'd1, 1'b0, 17'h102, 32'h0);
      step_wait();
      chk("ld_half_zext", ls_rdata_out, 32'h00008322);
      chk("ld_half_latency", cyc - 1, 3);
      end_done(1'b0, 1'b1);

      req_ls(1'b0, 2'd0, 1'b1, 17'h100, 32'h0);
      step_wait();
      chk("ld_byte_sext", ls_rdata_out, 32'hFFFFFF80);
      chk("ld_byte_latency", cyc - 1, 2);
      end_done(1'b0, 1'b1);

      // size 3 asks for 8 bytes; clamped to the 4-byte word
      req_ls(1'b0, 2'd3, 1'b0, 17'h100, 32'h0);
      step_wait();
      chk("ld_clamp_data", ls_rdata_out, 32'h83221180);
      chk("ld_clamp_nacc", nlog, 4);
      end_done(1'b0, 1'b1);

      req_ls(1'b1, 2'd0, 1'b0, 17'h10, 32'hDEADBEEF);
      step_wait();
      chk("st_byte_done", {if_done_out, ls_done_out}, 2'b01);
      chk("st_byte_latency", cyc - 1, 1);
      chk("st_byte_wcycles", nwr, 1);
      end_done(1'b0, 1'b1);
      chk("st_byte_ram10", ram[17'h10], 8'hEF);
      chk("st_byte_ram11", ram[17'h11], 8'h66);

      // Arbitration from a fresh reset: fetch first, then strict alternation
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
      tick();
      if_addr_in  = 17'h100;
      if_valid_in = 1'b1;
      req_ls(1'b0, 2'd0, 1'b0, 17'h103, 32'h0);
      step_wait();
      chk("arb1_fetch_first", {if_done_out, ls_done_out}, 2'b10);
      chk("arb1_fetch_data", if_data_out, 32'h83221180);
      end_done(1'b1, 1'b0);
      if_addr_in  = 17'h1FFFE;
      if_valid_in = 1'b1;
      step_wait();
      chk("arb2_load_next", {if_done_out, ls_done_out}, 2'b01);
      chk("arb2_load_data", ls_rdata_out, 32'h00000083);
      end_done(1'b0, 1'b1);
      req_ls(1'b0, 2'd0, 1'b1, 17'h100, 32'h0);
      step_wait();
      chk("arb3_fetch_again", {if_done_out, ls_done_out}, 2'b10);
      chk("wrap_fetch_data", if_data_out, 32'hD4C3B2A1);
      chk("wrap_fetch_addrs", {log_a[0], log_a[1], log_a[2], log_a[3]},
          {17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001});
      chk("ls_rdata_held", ls_rdata_out, 32'h00000083);
      end_done(1'b1, 1'b0);
      step_wait();
      chk("arb4_load_last", {if_done_out, ls_done_out}, 2'b01);
      chk("arb4_load_data", ls_rdata_out, 32'hFFFFFF80);
      chk("if_data_held", if_data_out, 32'hD4C3B2A1);
      end_done(1'b0, 1'b1);

      // Reset in the middle of a word store: after E2 bytes 0 and 1 are in RAM
      req_ls(1'b1, 2'd2, 1'b0, 17'h20, 32'h44332211);
      tick();
      tick();
      tick();
      rst_n_in = 1'b0;
      #1;
      chk("midrst_mem_en", mem_en_out, 1'b0);
      chk("midrst_mem_r_nw", mem_r_nw_out, 1'b1);
      chk("midrst_mem_a", mem_a_out, 17'h0);
      ls_valid_in = 1'b0;
      tick();
      chk("midrst_no_done", ls_done_out, 1'b0);
      tick();
      rst_n_in = 1'b1;
      chk("midrst_ram", {ram[17'h20], ram[17'h21], ram[17'h22], ram[17'h23]}, 32'h11220000);
      req_ls(1'b0, 2'd2, 1'b0, 17'h20, 32'h0);
      step_wait();
      chk("post_rst_load", ls_rdata_out, 32'h00002211);
      chk("post_rst_latency", cyc - 1, 5);
      end_done(1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_byte_ctrl.md
# ram_byte_ctrl

Parametrised memory controller that turns multi-byte fetch and load/store requests into byte-serial accesses on the 8-bit synchronous RAM port (`en`/`r_nw`/`a`/`d_in`/`d_out`, one-cycle registered read). It sits between the core's instruction-fetch and load-store units and the on-board RAM. It arbitrates the two channels round-robin, assembles little-endian words, and sign- or zero-extends loads.

## Interface
- `ADDR_WIDTH`, 17, RAM byte-address width
- `DATA_BYTES`, 4, bytes per full word; data buses are `8*DATA_BYTES` bits
- `clk_in` input 1: system clock, all state on rising edge
- `rst_n_in` input 1: asynchronous, active-low reset
- `if_valid_in` input 1: fetch request, held until `if_done_out`
- `if_addr_in` input ADDR_WIDTH: fetch byte address
- `if_done_out` output 1: one-cycle completion pulse
- `if_data_out` output 8*DATA_BYTES: fetched word, valid with done, held until next fetch completes
- `ls_valid_in` input 1: load/store request, held until `ls_done_out`
- `ls_wr_in` input 1: 1 = store, 0 = load
- `ls_size_in` input 2: access of 2^size bytes; clamped to DATA_BYTES
- `ls_sext_in` input 1: loads only; 1 = sign-extend, 0 = zero-extend
- `ls_addr_in` input ADDR_WIDTH: byte address
- `ls_wdata_in` input 8*DATA_BYTES: store data, low bytes used
- `ls_done_out` output 1: one-cycle completion pulse
- `ls_rdata_out` output 8*DATA_BYTES: extended load result, valid with done, held until next load completes
- `mem_en_out` output 1: RAM enable
- `mem_r_nw_out` output 1: 1 = read, 0 = write
- `mem_a_out` output ADDR_WIDTH: RAM byte address
- `mem_d_out` output 8: RAM write data
- `mem_d_in` input 8: RAM read data (registered in RAM, one cycle after address)

## Operation
- States: IDLE, IF, LOAD, STORE. All outputs registered.
- Reset, asynchronous and immediate even mid-transfer: state IDLE, counters 0, round-robin pointer = fetch, all outputs 0 except `mem_r_nw_out`=1.
- Acceptance: only in IDLE with both done outputs low. Address, size, wdata and sext are latched.
- Arbitration:
  - Single valid: that channel wins.
  - Both valid: the channel not served last wins.
  - Pointer updates on every acceptance.
- Byte count N:
  - IF: DATA_BYTES.
  - LOAD/STORE: min(2^`ls_size_in`, DATA_BYTES).
- Byte i uses address (addr + i) mod 2^ADDR_WIDTH. Wrap past top is legal.
- Byte i maps to data bits [8i+7:8i] (little-endian).
- Load extension: bits above 8N-1 filled with bit 8N-1 if sext, else 0. Fetch is never extended.
- Store writes only bytes 0..N-1.
- Idle RAM port: `mem_en_out`=0, `mem_r_nw_out`=1, address and data hold previous value.

## Timing
- E0 = acceptance edge; Ek = k-th edge after it.
- Read (IF/LOAD):
  - Byte i address is driven in the cycle after Ei, with `mem_en_out`=1 and `mem_r_nw_out`=1.
  - `mem_d_in` for byte i is captured at E(i+2).
  - Done pulse and data output are updated at E(N+1); state returns to IDLE at the same edge.
  - Latency: N+1 cycles (word: 5).
- Write (STORE):
  - Byte i is driven after Ei with `mem_r_nw_out`=0 and is written by the RAM at E(i+1).
  - `mem_en_out` drops and `ls_done_out` pulses after EN.
  - Latency: N cycles.
- Requester must drop valid by the end of its done cycle. The earliest next acceptance is the edge ending the done cycle +1.
- Back-to-back gap: one done cycle plus one acceptance edge. No accesses overlap.
- A request arriving mid-transfer waits in IDLE arbitration. It is never dropped.
- Reset asserted mid-STORE: bytes already written stay written, remaining bytes are not written, no done pulse.

## Test plan
- RAM preloaded 0x100..0x103 = 0x80,0x11,0x22,0x83; LOAD size 2, sext 1 at 0x100 -> `ls_rdata_out`=0x83221180, done 5 cycles after acceptance.
- LOAD size 1, sext 0 at 0x102 -> 0x00008322. LOAD size 0, sext 1 at 0x100 -> 0xFFFFFF80.
- STORE size 0, wdata 0xDEADBEEF at 0x10 -> only 0x10 = 0xEF, 0x11 unchanged, done after 1 cycle with one `mem_r_nw_out`=0 cycle.
- Fetch and load both valid from reset -> fetch first, then load. Fetch re-requested while load pending -> alternation continues, no starvation.
- Fetch at 0x1FFFE (ADDR_WIDTH 17) -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 in order, word assembled correctly.
- STORE word, `rst_n_in` low after byte 1 is written -> outputs reset the same cycle, bytes 2-3 unchanged, next request after reset served normally.
